// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with flush squash and a saturating stall counter.
// Build option PIPE_STAGE_SKID_EN adds a skid entry so that ready_o is registered.
//   state | meaning
//   EMPTY | nothing held, data_o shows the bubble value
//   ONE   | main entry holds the payload presented on data_o
//   FULL  | main and skid entries both held (skid build only)
module pipe_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [31:0] BUBBLE_VAL = 32'h0000_0000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_VAL);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               valid_q;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [1:0]         occ_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, emit;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               ready_q;

  assign ready_o = ready_q;
`else
  assign ready_o = ~valid_q | ready_i;
`endif

  assign accept = valid_i & ready_o & ~flush_i;
  assign emit   = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = data_i;
        end
      end
      ONE: begin
        if (accept && emit) begin
          main_d = data_i;
`ifdef PIPE_STAGE_SKID_EN
        end else if (accept) begin
          state_d = FULL;
          skid_d  = data_i;
`endif
        end else if (emit) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      FULL: begin
        if (emit) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
`endif
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
      end
    endcase
    // Squash wins over both accept and emit.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = BUBBLE;
`endif
    end
  end

  assign cnt_d = (valid_q && !ready_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      main_q  <= BUBBLE;
      occ_q   <= 2'd0;
      cnt_q   <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= BUBBLE;
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      main_q  <= main_d;
      occ_q   <= (state_d == FULL) ? 2'd2 : ((state_d == ONE) ? 2'd1 : 2'd0);
      cnt_q   <= cnt_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
`endif
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = main_q;
  assign occupancy_o = occ_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: queue reference model plus directed scenarios.
module tb_pipe_stage;

  localparam logic [31:0] BUB = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, valid_i, flush_i, ready_i;
  logic [31:0] data_i;
  logic        ready_o, valid_o;
  logic [31:0] data_o;
  logic [1:0]  occ_o;
  logic [15:0] cnt_o;
  logic        r2, v2;
  logic [31:0] d2;
  logic [1:0]  occ2;
  logic [1:0]  cnt2;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  logic [31:0] emit_log[$];
  int          mcnt, mcnt2;
  logic        tog_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(32), .BUBBLE_VAL(BUB), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .occupancy_o(occ_o), .stall_cnt_o(cnt_o));

  pipe_stage #(.WIDTH(32), .BUBBLE_VAL(BUB), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r2), .data_i(data_i),
    .flush_i(flush_i), .valid_o(v2), .ready_i(ready_i), .data_o(d2),
    .occupancy_o(occ2), .stall_cnt_o(cnt2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs from the held queue, advanced on the values the next edge samples.
  always @(negedge clk) begin
    logic        ev, er, acc, em;
    logic [31:0] ed;
    if (rst) begin
      mq.delete();
      mcnt  = 0;
      mcnt2 = 0;
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_data", data_o, BUB);
      check("rst_occ", {30'd0, occ_o}, 32'd0);
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      check("rst_stall", {16'd0, cnt_o}, 32'd0);
    end else begin
      ev = (mq.size() != 0);
      ed = ev ? mq[0] : BUB;
      er = (CAP == 2) ? (mq.size() < 2) : (!ev || ready_i);
      check("valid_o", {31'd0, valid_o}, {31'd0, ev});
      check("data_o", data_o, ed);
      check("occupancy_o", {30'd0, occ_o}, mq.size());
      check("ready_o", {31'd0, ready_o}, {31'd0, er});
      check("stall_cnt", {16'd0, cnt_o}, mcnt);
      check("stall_cnt_w2", {30'd0, cnt2}, mcnt2);
      if (valid_o && ready_i) emit_log.push_back(data_o);
      acc = valid_i && er && !flush_i;
      em  = ev && ready_i;
      if (ev && !ready_i) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt2 < 3) mcnt2++;
      end
      if (flush_i) mq.delete();
      else begin
        if (em) void'(mq.pop_front());
        if (acc) mq.push_back(data_i);
      end
    end
  end

  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      ready_i = ~ready_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    logic a;
    data_i  = d;
    valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = ready_o && !flush_i;
      tick();
      if (a) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: data %h never accepted", d);
  endtask

  task automatic check_log(input string name, input logic [31:0] exp[$]);
    check({name, "_len"}, emit_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < emit_log.size(); i++)
      check(name, emit_log[i], exp[i]);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [1:0]  stall_exp[5];
    rst = 1'b1; valid_i = 1'b0; data_i = '0; flush_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // First transfer right after reset release.
    rst = 1'b0; valid_i = 1'b1; data_i = 32'h1111_1111; ready_i = 1'b1;
    tick();
    check("first_valid", {31'd0, valid_o}, 32'd1);
    check("first_data", data_o, 32'h1111_1111);
    check("first_occ", {30'd0, occ_o}, 32'd1);
    valid_i = 1'b0;
    tick();
    check("drain_valid", {31'd0, valid_o}, 32'd0);
    check("drain_data", data_o, BUB);

    // Back-pressured stream A,B,C.
    emit_log.delete();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'hA;
    tick();
    data_i = 32'hB;
    tick();
    check("stall_head", data_o, 32'hA);
    check("stall_ready", {31'd0, ready_o}, 32'd0);
    check("stall_occ", {30'd0, occ_o}, CAP);
    ready_i = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    send(32'hC);
`else
    send(32'hB);
    send(32'hC);
`endif
    valid_i = 1'b0;
    repeat (3) tick();
    exp_q = '{32'hA, 32'hB, 32'hC};
    check_log("order_abc", exp_q);

    // Flush with the stage held, incoming 0xD must vanish.
    emit_log.delete();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h5;
    tick();
    data_i = 32'h6;
    tick();
    flush_i = 1'b1; data_i = 32'hD;
    tick();
    check("flush_valid", {31'd0, valid_o}, 32'd0);
    check("flush_data", data_o, BUB);
    check("flush_occ", {30'd0, occ_o}, 32'd0);
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    repeat (3) tick();
    check("flush_log_len", emit_log.size(), 32'd0);

    // Saturating stall counter on the 2-bit instance.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h77;
    tick();
    data_i = 32'h78;
    stall_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      tick();
      valid_i = 1'b0;
      check("sat_cnt2", {30'd0, cnt2}, {30'd0, stall_exp[i]});
      check("sat_cnt16", {16'd0, cnt_o}, i + 1);
    end

    // Asynchronous reset away from the clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_valid", {31'd0, valid_o}, 32'd0);
    check("async_occ", {30'd0, occ_o}, 32'd0);
    check("async_cnt", {16'd0, cnt_o}, 32'd0);
    check("async_cnt2", {30'd0, cnt2}, 32'd0);
    check("async_data", data_o, BUB);
    tick();
    rst = 1'b0; ready_i = 1'b1;

    // Downstream ready toggling every cycle with continuous input.
    emit_log.delete();
    exp_q.delete();
    tog_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h100 + i);
      send(32'h100 + i);
    end
    valid_i = 1'b0;
    tog_en = 1'b0;
    tick();
    ready_i = 1'b1;
    repeat (4) tick();
    check_log("toggle_order", exp_q);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      valid_i = ($urandom_range(3) != 0);
      ready_i = ($urandom_range(2) != 0);
      flush_i = ($urandom_range(15) == 0);
      data_i  = $urandom;
      tick();
    end
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits.
REQ-002 Parameter BUBBLE_VAL, default 32'h0000_0000 (zero-extended/truncated to WIDTH): data_o value when empty or flushed (NOP encoding).
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Port clk_i  input  1: sole clock; all state on rising edge.
REQ-005 Port rst_i  input  1: asynchronous, active-high reset.
REQ-006 Port valid_i  input  1: upstream payload valid.
REQ-007 Port ready_o  output  1: stage accepts payload this cycle.
REQ-008 Port data_i  input  WIDTH: upstream payload.
REQ-009 Port flush_i  input  1: discard all held and incoming payloads (branch/jump squash).
REQ-010 Port valid_o  output  1: downstream payload valid.
REQ-011 Port ready_i  input  1: downstream accepts payload (deasserted = hazard stall).
REQ-012 Port data_o  output  WIDTH: downstream payload.
REQ-013 Port occupancy_o  output  2: entries held (0..2).
REQ-014 Port stall_cnt_o  output  CNT_W: cycles with valid_o=1 and ready_i=0.

Function
REQ-015 Accept = valid_i & ready_o & ~flush_i; emit = valid_o & ready_i.
REQ-016 Payloads leave in acceptance order; none duplicated, none dropped except by flush.
REQ-017 Latency: accepted payload reaches data_o/valid_o the cycle after acceptance when stage was empty.
REQ-018 data_o SHALL equal BUBBLE_VAL whenever valid_o=0.
REQ-019 State machine (skid build): EMPTY (occ 0), ONE (main full, occ 1), FULL (main+skid full, occ 2).
REQ-020 EMPTY: accept -> ONE; else stay.
REQ-021 ONE: accept&emit -> ONE (main reloads); accept&~emit -> FULL (input into skid); ~accept&emit -> EMPTY; else stay.
REQ-022 FULL: emit -> ONE (skid moves to main); else stay; ready_o=0 in FULL.
REQ-023 ready_o registered in skid build: ready_o = (state != FULL); no combinational ready_i->ready_o path.
REQ-024 flush_i=1 (any state): next state EMPTY, valid_o=0 next cycle, same-cycle input dropped; flush has priority over accept and emit.
REQ-025 Emit in the flush cycle still completes downstream (valid_o/data_o unchanged that cycle).
REQ-026 stall_cnt_o increments by 1 each cycle valid_o=1 & ready_i=0, saturates at 2^CNT_W-1, unaffected by flush.
REQ-027 occupancy_o reflects current state (0/1/2), registered.

Reset
REQ-028 rst_i=1 asynchronously forces: state EMPTY, valid_o=0, data_o=BUBBLE_VAL, occupancy_o=0, stall_cnt_o=0, skid entry invalid.
REQ-029 ready_o=1 during and after reset in skid build; reset mid-transfer discards all held payloads.
REQ-030 First acceptance possible on first rising edge after rst_i deasserts.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: two-entry skid behaviour per REQ-019..REQ-023.
REQ-032 Macro undefined: single register, no skid entry; ready_o = ~valid_o | ready_i (combinational); states EMPTY/ONE only; occupancy_o max 1; all other requirements unchanged.

Verification
REQ-033 Reset then valid_i=1, data_i=32'h1111_1111, ready_i=1 -> next cycle valid_o=1, data_o=32'h1111_1111, occupancy_o=1.
REQ-034 Skid build: stream 0xA,0xB,0xC with ready_i=0 from cycle 1 -> 0xA held, 0xB in skid, ready_o=0, occupancy_o=2; release ready_i -> 0xA,0xB,0xC emitted in order.
REQ-035 FULL state, flush_i=1 with valid_i=1 data 0xD -> next cycle valid_o=0, data_o=BUBBLE_VAL, occupancy_o=0, 0xD never emitted.
REQ-036 CNT_W=2, hold ready_i=0 for 5 cycles with valid_o=1 -> stall_cnt_o reads 1,2,3,3,3.
REQ-037 rst_i asserted mid-cycle in FULL (not on clock edge) -> valid_o=0, occupancy_o=0, stall_cnt_o=0 immediately, before next edge.
REQ-038 Non-skid build, valid_o=1, ready_i toggling 1/0 each cycle with continuous input -> ready_o follows ready_i same cycle, no loss/duplication over 8 payloads.
